// File: rtl/mini_cpu_param_if.sv
// Display handshake bundle between the CPU (master) and a display controller (slave).
interface mini_cpu_param_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              disp_valid;
    logic              disp_ready;
    logic [2:0]        disp_opcode;
    logic [REG_AW-1:0] disp_reg;
    logic [DATA_W-1:0] disp_value;

    modport master (
        output disp_valid,
        output disp_opcode,
        output disp_reg,
        output disp_value,
        input  disp_ready
    );

    modport slave (
        input  disp_valid,
        input  disp_opcode,
        input  disp_reg,
        input  disp_value,
        output disp_ready
    );
endinterface

// File: rtl/mini_cpu_param.sv
// Button-driven mini CPU: one instruction per press of an active-low button,
// small register file, sequential shift-add multiplier and a valid/ready
// display record carrying the outcome of each instruction.
module mini_cpu_param #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int INSTR_W = 18
) (
    input  logic               clk,
    input  logic               ligar,
    input  logic               enviar,
    input  logic [INSTR_W-1:0] instr,
    mini_cpu_param_if.master   disp,
    output logic               busy,
    output logic               ovf,
    output logic [15:0]        instr_count
);
    localparam int REG_AW = $clog2(NREGS);
    localparam int L      = INSTR_W - 3 - 2 * REG_AW;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLEAR, OP_DISPLAY
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE, EXEC, MUL_ITER, WRITE, DISP, RELEASE
    } state_t;

    state_t              state_q;
    logic [1:0]          sync_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   opA_q, opB_q;
    logic [2*DATA_W-1:0] mulAcc_q, mulMcand_q;
    logic [DATA_W-1:0]   mulMplier_q;
    logic [CNT_W-1:0]    mulCnt_q;
    logic                mulNeg_q;
    logic                dispValid_q;
    logic [2:0]          dispOpcode_q;
    logic [REG_AW-1:0]   dispReg_q;
    logic [DATA_W-1:0]   dispValue_q;
    logic                busy_q, ovf_q;
    logic [15:0]         count_q;

    logic                enviarSync;
    opcode_t             op;
    logic [REG_AW-1:0]   rd, rs1, rs2;
    logic [L-1:0]        field;
    logic [DATA_W-1:0]   immMag, imm, rs1Val, rs2Val, absA, absImm;
    logic [2*DATA_W-1:0] mulProd;
    logic [DATA_W-1:0]   result_d, wrVal_d;
    logic                ovf_d;

    assign enviarSync = sync_q[1];
    assign op     = opcode_t'(instr_q[INSTR_W-1 -: 3]);
    assign rd     = instr_q[INSTR_W-4 -: REG_AW];
    assign rs1    = instr_q[INSTR_W-4-REG_AW -: REG_AW];
    assign field  = instr_q[L-1:0];
    assign rs2    = field[L-1 -: REG_AW];
    assign immMag = DATA_W'(field[L-2:0]);
    assign imm    = field[L-1] ? -immMag : immMag;
    assign absA   = rs1Val[DATA_W-1] ? -rs1Val : rs1Val;
    assign absImm = imm[DATA_W-1] ? -imm : imm;
    assign mulProd = mulNeg_q ? -mulAcc_q : mulAcc_q;

    // Register file read; indices outside the implemented range read as zero
    always_comb begin
        rs1Val = '0;
        rs2Val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rs1 == REG_AW'(i)) rs1Val = regs_q[i];
            if (rs2 == REG_AW'(i)) rs2Val = regs_q[i];
        end
    end

    // Result and signed-overflow computation from the operands latched in EXEC
    always_comb begin
        result_d = '0;
        ovf_d    = ovf_q;
        case (op)
            OP_ADD, OP_ADDI: begin
                result_d = opA_q + opB_q;
                ovf_d    = (opA_q[DATA_W-1] == opB_q[DATA_W-1]) &&
                           (result_d[DATA_W-1] != opA_q[DATA_W-1]);
            end
            OP_SUB, OP_SUBI: begin
                result_d = opA_q - opB_q;
                ovf_d    = (opA_q[DATA_W-1] != opB_q[DATA_W-1]) &&
                           (result_d[DATA_W-1] != opA_q[DATA_W-1]);
            end
            OP_MUL: begin
                result_d = mulProd[DATA_W-1:0];
                ovf_d    = mulProd[2*DATA_W-1:DATA_W] != {DATA_W{mulProd[DATA_W-1]}};
            end
            default: begin
                result_d = '0;
                ovf_d    = ovf_q;
            end
        endcase
        wrVal_d = (op == OP_LOAD) ? opB_q : result_d;
    end

    // Two-flop synchronizer for the asynchronous, active-low button
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], enviar};
    end

    // Main control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            opA_q        <= '0;
            opB_q        <= '0;
            mulAcc_q     <= '0;
            mulMcand_q   <= '0;
            mulMplier_q  <= '0;
            mulCnt_q     <= '0;
            mulNeg_q     <= 1'b0;
            dispValid_q  <= 1'b0;
            dispOpcode_q <= '0;
            dispReg_q    <= '0;
            dispValue_q  <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!enviarSync) begin
                        instr_q <= instr;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    opA_q       <= rs1Val;
                    opB_q       <= (op == OP_ADD || op == OP_SUB) ? rs2Val : imm;
                    mulAcc_q    <= '0;
                    mulMcand_q  <= {{DATA_W{1'b0}}, absA};
                    mulMplier_q <= absImm;
                    mulCnt_q    <= '0;
                    mulNeg_q    <= rs1Val[DATA_W-1] ^ imm[DATA_W-1];
                    state_q     <= (op == OP_MUL) ? MUL_ITER : WRITE;
                end
                MUL_ITER: begin
                    if (mulMplier_q[0]) mulAcc_q <= mulAcc_q + mulMcand_q;
                    mulMcand_q  <= mulMcand_q << 1;
                    mulMplier_q <= mulMplier_q >> 1;
                    mulCnt_q    <= mulCnt_q + 1'b1;
                    if (mulCnt_q == CNT_W'(DATA_W - 1)) state_q <= WRITE;
                end
                WRITE: begin
                    case (op)
                        OP_CLEAR: begin
                            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
                            ovf_q <= 1'b0;
                        end
                        OP_DISPLAY: ;
                        OP_LOAD: begin
                            for (int i = 0; i < NREGS; i++)
                                if (rd == REG_AW'(i)) regs_q[i] <= wrVal_d;
                        end
                        default: begin
                            for (int i = 0; i < NREGS; i++)
                                if (rd == REG_AW'(i)) regs_q[i] <= wrVal_d;
                            ovf_q <= ovf_d;
                        end
                    endcase
                    dispValid_q  <= 1'b1;
                    dispOpcode_q <= op;
                    dispReg_q    <= (op == OP_DISPLAY) ? rs1 : rd;
                    case (op)
                        OP_DISPLAY: dispValue_q <= opA_q;
                        OP_CLEAR:   dispValue_q <= '0;
                        default:    dispValue_q <= wrVal_d;
                    endcase
                    count_q <= count_q + 16'd1;
                    state_q <= DISP;
                end
                DISP: begin
                    if (disp.disp_ready) begin
                        dispValid_q <= 1'b0;
                        state_q     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (enviarSync) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign disp.disp_valid  = dispValid_q;
    assign disp.disp_opcode = dispOpcode_q;
    assign disp.disp_reg    = dispReg_q;
    assign disp.disp_value  = dispValue_q;
    assign busy        = busy_q;
    assign ovf         = ovf_q;
    assign instr_count = count_q;
endmodule

// File: tb/tb_mini_cpu_param.sv
// Directed bench for mini_cpu_param: a 16-bit and an 8-bit instance share the
// same stimulus; a select flag chooses which instance is being observed.
module tb_mini_cpu_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ligar, enviar, readyIn, sel;
    logic [17:0] instrIn;
    logic        busyA, busyB, ovfA, ovfB;
    logic [15:0] cntA, cntB;

    mini_cpu_param_if #(.DATA_W(16), .REG_AW(4)) ifA ();
    mini_cpu_param_if #(.DATA_W(8),  .REG_AW(4)) ifB ();
    assign ifA.disp_ready = readyIn;
    assign ifB.disp_ready = readyIn;

    mini_cpu_param #(.DATA_W(16), .NREGS(16), .INSTR_W(18)) dutA (
        .clk(clk), .ligar(ligar), .enviar(enviar), .instr(instrIn), .disp(ifA),
        .busy(busyA), .ovf(ovfA), .instr_count(cntA)
    );
    mini_cpu_param #(.DATA_W(8), .NREGS(16), .INSTR_W(18)) dutB (
        .clk(clk), .ligar(ligar), .enviar(enviar), .instr(instrIn), .disp(ifB),
        .busy(busyB), .ovf(ovfB), .instr_count(cntB)
    );

    logic        obsValid, obsBusy, obsOvf;
    logic [15:0] obsValue, obsCount;
    logic [3:0]  obsReg;
    logic [2:0]  obsOp;
    assign obsValid = sel ? ifB.disp_valid : ifA.disp_valid;
    assign obsBusy  = sel ? busyB : busyA;
    assign obsOvf   = sel ? ovfB : ovfA;
    assign obsValue = sel ? {8'h00, ifB.disp_value} : ifA.disp_value;
    assign obsCount = sel ? cntB : cntA;
    assign obsReg   = sel ? ifB.disp_reg : ifA.disp_reg;
    assign obsOp    = sel ? ifB.disp_opcode : ifA.disp_opcode;

    int          assertCount = 0;
    int          failCount   = 0;
    int          lat, busyCnt;
    logic [15:0] capValue;
    logic [3:0]  capReg;
    logic [2:0]  capOp;

    function automatic logic [17:0] mk(input logic [2:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [6:0] f);
        return {op, rd, rs1, f};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Press the button with one instruction, measure latency, capture the record, release
    task automatic applyStimulus(input logic [17:0] word);
        int n;
        instrIn = word;
        enviar  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obsBusy && n < 20);
        checkOutput("start", obsBusy, 1);
        lat = 0;
        busyCnt = 0;
        while (!obsValid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (obsBusy) busyCnt++;
        end
        checkOutput("validSeen", obsValid, 1);
        capValue = obsValue;
        capReg   = obsReg;
        capOp    = obsOp;
        enviar   = 1'b1;
        n = 0;
        while (obsBusy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("backToIdle", obsBusy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic stable;
        sel = 1'b0; ligar = 1'b1; enviar = 1'b1; readyIn = 1'b1; instrIn = '0;
        #1 ligar = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstValid", obsValid, 0);
        checkOutput("rstBusy",  obsBusy, 0);
        checkOutput("rstCount", obsCount, 0);
        checkOutput("rstOvf",   obsOvf, 0);
        checkOutput("rstValue", obsValue, 0);
        ligar = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noStartWithoutButton", obsBusy, 0);

        $display("[TB] 16-bit instance: basic arithmetic");
        applyStimulus(mk(3'd0, 4'd3, 4'd0, 7'h05));
        checkOutput("loadLatency", lat, 2);
        checkOutput("loadValue", capValue, 16'd5);
        checkOutput("loadReg", capReg, 3);
        checkOutput("loadOp", capOp, 0);
        checkOutput("loadCount", obsCount, 1);
        applyStimulus(mk(3'd2, 4'd4, 4'd3, 7'h42));
        checkOutput("addiValue", capValue, 16'd3);
        checkOutput("addiReg", capReg, 4);
        checkOutput("addiOvf", obsOvf, 0);
        applyStimulus(mk(3'd3, 4'd5, 4'd4, 7'h18));
        checkOutput("subValue", capValue, 16'hFFFE);
        checkOutput("subOvf", obsOvf, 0);
        applyStimulus(mk(3'd7, 4'd0, 4'd3, 7'h00));
        checkOutput("dispR3Value", capValue, 16'd5);
        checkOutput("dispR3Reg", capReg, 3);
        checkOutput("dispR3Op", capOp, 7);
        checkOutput("dispR3Count", obsCount, 4);

        $display("[TB] 16-bit instance: multiply");
        applyStimulus(mk(3'd0, 4'd1, 4'd0, 7'h3F));
        checkOutput("loadR1", capValue, 16'h003F);
        applyStimulus(mk(3'd5, 4'd2, 4'd1, 7'h3F));
        checkOutput("mul16Latency", lat, 18);
        checkOutput("mul16Value", capValue, 16'h0F81);
        checkOutput("mul16Ovf", obsOvf, 0);
        applyStimulus(mk(3'd5, 4'd2, 4'd2, 7'h3F));
        checkOutput("mul16BigValue", capValue, 16'hD0BF);
        checkOutput("mul16BigOvf", obsOvf, 1);
        applyStimulus(mk(3'd7, 4'd0, 4'd2, 7'h00));
        checkOutput("dispR2Value", capValue, 16'hD0BF);
        checkOutput("ovfKeptByDisplay", obsOvf, 1);
        applyStimulus(mk(3'd5, 4'd6, 4'd4, 7'h42));
        checkOutput("mulNegValue", capValue, 16'hFFFA);
        checkOutput("mulNegOvf", obsOvf, 0);

        $display("[TB] 16-bit instance: display back-pressure");
        readyIn = 1'b0;
        instrIn = mk(3'd1, 4'd7, 4'd3, 7'h20);
        enviar  = 1'b0;
        n = 0;
        while (!obsValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stallValid", obsValid, 1);
        capValue = obsValue;
        capReg   = obsReg;
        capOp    = obsOp;
        stable   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            enviar  = ~enviar;
            instrIn = mk(3'd0, 4'd9, 4'd0, 7'h01);
            @(negedge clk);
            if (!obsValid || obsValue !== capValue || obsReg !== capReg || obsOp !== capOp)
                stable = 1'b0;
        end
        checkOutput("stallStable", stable, 1);
        checkOutput("stallValue", capValue, 16'd8);
        checkOutput("stallReg", capReg, 7);
        checkOutput("stallCount", obsCount, 10);
        enviar  = 1'b1;
        readyIn = 1'b1;
        @(negedge clk);
        checkOutput("readyDropsValid", obsValid, 0);
        n = 0;
        while (obsBusy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stallIdle", obsBusy, 0);
        repeat (6) @(negedge clk);
        checkOutput("noQueueCount", obsCount, 10);
        checkOutput("noQueueBusy", obsBusy, 0);

        $display("[TB] 16-bit instance: clear");
        applyStimulus(mk(3'd5, 4'd9, 4'd2, 7'h3F));
        checkOutput("mulWrapValue", capValue, 16'h5F01);
        checkOutput("mulWrapOvf", obsOvf, 1);
        applyStimulus(mk(3'd6, 4'd0, 4'd0, 7'h00));
        checkOutput("clearValue", capValue, 0);
        checkOutput("clearOp", capOp, 6);
        checkOutput("clearOvf", obsOvf, 0);
        applyStimulus(mk(3'd7, 4'd0, 4'd3, 7'h00));
        checkOutput("dispAfterClear", capValue, 0);
        checkOutput("ovfAfterClear", obsOvf, 0);
        checkOutput("countAfterClear", obsCount, 13);

        $display("[TB] 8-bit instance: multiply and reset in MUL_ITER");
        ligar = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        checkOutput("rst8Count", obsCount, 0);
        @(negedge clk);
        ligar = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(mk(3'd0, 4'd1, 4'd0, 7'h3F));
        checkOutput("load8Value", capValue, 16'h003F);
        applyStimulus(mk(3'd5, 4'd2, 4'd1, 7'h3F));
        checkOutput("mul8Latency", lat, 10);
        checkOutput("mul8BusyCycles", busyCnt, 10);
        checkOutput("mul8Value", capValue, 16'h0081);
        checkOutput("mul8Ovf", obsOvf, 1);
        checkOutput("mul8Count", obsCount, 2);

        instrIn = mk(3'd5, 4'd3, 4'd1, 7'h3F);
        enviar  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obsBusy && n < 20);
        checkOutput("mulStart", obsBusy, 1);
        enviar = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midMulBusy", obsBusy, 1);
        #2 ligar = 1'b0;
        #1;
        checkOutput("asyncValid", obsValid, 0);
        checkOutput("asyncOp", obsOp, 0);
        checkOutput("asyncReg", obsReg, 0);
        checkOutput("asyncValue", obsValue, 0);
        checkOutput("asyncBusy", obsBusy, 0);
        checkOutput("asyncOvf", obsOvf, 0);
        checkOutput("asyncCount", obsCount, 0);
        @(negedge clk);
        @(negedge clk);
        ligar = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postRstIdle", obsBusy, 0);
        applyStimulus(mk(3'd7, 4'd0, 4'd1, 7'h00));
        checkOutput("postRstR1", capValue, 0);
        checkOutput("postRstR1Reg", capReg, 1);
        checkOutput("postRstCount", obsCount, 1);
        applyStimulus(mk(3'd7, 4'd0, 4'd2, 7'h00));
        checkOutput("postRstR2", capValue, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/mini_cpu_param.md
MINI_CPU_PARAM -- requirements
Module: mini_cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and datapath width, range 4..32.
REQ-002 SHALL have parameter NREGS, default 16: register count, range 2..16; REG_AW = clog2(NREGS).
REQ-003 SHALL have parameter INSTR_W, default 18: instruction width, at least 3+3*REG_AW+1; L = INSTR_W-3-2*REG_AW.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 ligar  in  1  reset, asynchronous, active-low.
REQ-006 enviar  in  1  submit button, active-low, asynchronous to clk.
REQ-007 instr  in  INSTR_W  opcode = top 3 bits, then rd (REG_AW), rs1 (REG_AW), low field F (L bits); rs2 = F[L-1 -: REG_AW]; imm sign = F[L-1], imm magnitude = F[L-2:0].
REQ-008 disp_ready  in  1  display controller accepts the current record.
REQ-009 disp_valid  out  1  display record valid.
REQ-010 disp_opcode  out  3  opcode of the displayed instruction.
REQ-011 disp_reg  out  REG_AW  register index shown.
REQ-012 disp_value  out  DATA_W  value shown.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 ovf  out  1  overflow flag of the last arithmetic write.
REQ-015 instr_count  out  16  count of completed instructions.

Function
REQ-016 enviar SHALL pass through a 2-flop synchronizer (flops reset to 1); only the synchronized value is used.
REQ-017 Opcodes SHALL be: 000 LOAD rd=imm; 001 ADD rd=rs1+rs2; 010 ADDI rd=rs1+imm; 011 SUB rd=rs1-rs2; 100 SUBI rd=rs1-imm; 101 MUL rd=rs1*imm; 110 CLEAR all regs=0; 111 DISPLAY show rs1.
REQ-018 imm SHALL be sign-magnitude: -mag when sign=1, else +mag, extended to DATA_W two's complement; -0 equals 0.
REQ-019 Add, sub and mul results SHALL be modulo 2^DATA_W.
REQ-020 ovf SHALL be set to signed overflow of ADD, ADDI, SUB, SUBI and MUL (product not representable in DATA_W signed); cleared by CLEAR; unchanged by LOAD and DISPLAY.
REQ-021 FSM states SHALL be IDLE, EXEC, MUL_ITER, WRITE, DISP, RELEASE.
REQ-022 IDLE: on synchronized enviar=0, go to EXEC and latch instr.
REQ-023 EXEC: latch operands from the register file, then go to WRITE (MUL: go to MUL_ITER).
REQ-024 MUL_ITER: sequential shift-add on magnitudes, exactly DATA_W cycles, then negate if operand signs differ; go to WRITE.
REQ-025 WRITE: on leaving it, perform the register write (none for DISPLAY), assert disp_valid, load the disp_* fields, and increment instr_count (wraps FFFF->0000); go to DISP.
REQ-026 Non-MUL latency SHALL be 3 edges from the IDLE sampling edge to disp_valid high; MUL SHALL add DATA_W edges.
REQ-027 disp_* fields:
- DISPLAY: reg rs1, value = contents of rs1.
- LOAD: reg rd, value imm.
- CLEAR: reg rd, value 0.
- All others: reg rd, value = result.
REQ-028 DISP: hold disp_valid and all disp_* fields stable until an edge with disp_ready=1, then drop disp_valid on that edge and go to RELEASE; disp_ready high on the first disp_valid cycle completes the handshake immediately.
REQ-029 RELEASE: go to IDLE on synchronized enviar=1; an early button release in DISP SHALL still pass through RELEASE.
REQ-030 enviar activity outside IDLE SHALL be ignored; no instruction queuing.
REQ-031 Register indices >= NREGS SHALL read as 0; writes to them SHALL be discarded.
REQ-032 Operands latched in EXEC SHALL be used even when rd equals rs1 or rs2.

Reset
REQ-033 ligar=0 SHALL immediately, in any state including MUL_ITER, force:
- state = IDLE, all registers = 0;
- disp_valid, disp_opcode, disp_reg, disp_value, busy, ovf, instr_count = 0.
REQ-034 After ligar rises, the first instruction SHALL be accepted only after synchronized enviar is seen low in IDLE.

Verification
REQ-035 LOAD rd=3, imm +5 -> disp_value=5, disp_reg=3, reg3=5, instr_count=1, non-MUL latency per REQ-026.
REQ-036 ADDI rd=4 rs1=3 imm -2 -> 3; SUB rd=5 rs1=4 rs2=3 -> 0xFFFE, ovf=0.
REQ-037 DATA_W=8: LOAD r1=63; MUL r2=r1*63 -> disp_value=0x81, ovf=1, busy high for the 8 MUL_ITER cycles.
REQ-038 disp_ready held 0 for 10 cycles while enviar toggles -> disp_valid and fields stable, no new instruction accepted; disp_ready=1 -> disp_valid falls next edge.
REQ-039 CLEAR then DISPLAY rs1=3 -> value 0, ovf=0, instr_count incremented twice.
REQ-040 ligar pulsed low during MUL_ITER -> all outputs 0 asynchronously; DISPLAY of any register afterwards -> 0.
